// File: rtl/alu_input_seq.sv
// alu_input_seq: operand-entry front end for the 4-bit ALU.
// Collects operand A, operand B and the opcode from the board switches on
// debounced enter presses. It then issues one request over a valid/ready
// handshake, waits for the result pulse (with a timeout), and holds the
// result for the seven-segment path.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   sw[3:0], sw_op[2:0]  raw operand / opcode switches
//   btn_enter, btn_clr   raw buttons, asynchronous to clk
//   alu_a/alu_b/alu_op   request payload, stable while alu_valid is high
//   alu_valid/alu_ready  request handshake
//   alu_result/rvalid    result return, rvalid is a one-cycle pulse
//   disp_val[3:0]        value shown on the display (combinational mux)
//   disp_stage[1:0]      0=A, 1=B, 2=OP, 3=RESULT
//   err                  response timeout, sticky until clear or next issue
//   busy                 request outstanding (ISSUE or WAIT)

// Button conditioner: 2-flop synchronizer, stable-count debouncer and a
// rising-edge press pulse.
//   clk, rst  clock, synchronous active-high reset
//   raw       raw button level
//   press     one-cycle pulse on the debounced 0->1 transition
module alu_input_seq_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sync;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchronizer is left out of reset so it keeps tracking the pin
    // through a reset pulse; that is what lets a button held across reset
    // be recognised as still held.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], raw};
    end

    assign sync = sync_q[1];

    // armed records that the button has been seen released since reset, so
    // a button held down through reset never produces a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!sync) begin
                armed <= 1'b1;
            end
            if (sync != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                    press <= sync & armed;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module alu_input_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT         = 64   // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic [2:0] sw_op,
    input  logic       btn_enter,
    input  logic       btn_clr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    output logic       alu_valid,
    input  logic       alu_ready,
    input  logic [3:0] alu_result,
    input  logic       alu_rvalid,
    output logic [3:0] disp_val,
    output logic [1:0] disp_stage,
    output logic       err,
    output logic       busy
);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, ISSUE, WAIT, SHOW} state_t;

    state_t        state, state_n;
    logic          enter_press, clr_press;
    logic [3:0]    result, result_n;
    logic [3:0]    a_n, b_n;
    logic [2:0]    op_n;
    logic          err_n, valid_n, busy_n;
    logic [1:0]    stage_n;
    logic [TW-1:0] wcnt, wcnt_n;

    alu_input_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .press (enter_press)
    );

    alu_input_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clr),
        .press (clr_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GET_A;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_valid  <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            disp_stage <= '0;
            wcnt       <= '0;
        end else begin
            state      <= state_n;
            alu_a      <= a_n;
            alu_b      <= b_n;
            alu_op     <= op_n;
            alu_valid  <= valid_n;
            result     <= result_n;
            err        <= err_n;
            busy       <= busy_n;
            disp_stage <= stage_n;
            wcnt       <= wcnt_n;
        end
    end

    // Registered status outputs are derived from the next state so they
    // always agree with the state register in the same cycle.
    always_comb begin
        state_n  = state;
        a_n      = alu_a;
        b_n      = alu_b;
        op_n     = alu_op;
        result_n = result;
        err_n    = err;
        wcnt_n   = wcnt;

        if (clr_press) begin
            state_n  = GET_A;
            a_n      = '0;
            b_n      = '0;
            op_n     = '0;
            result_n = '0;
            err_n    = 1'b0;
        end else begin
            case (state)
                GET_A: if (enter_press) begin
                    a_n     = sw;
                    state_n = GET_B;
                end
                GET_B: if (enter_press) begin
                    b_n     = sw;
                    state_n = GET_OP;
                end
                GET_OP: if (enter_press) begin
                    op_n    = sw_op;
                    err_n   = 1'b0;
                    state_n = ISSUE;
                end
                ISSUE: if (alu_valid && alu_ready) begin
                    wcnt_n = '0;
                    if (alu_rvalid) begin
                        result_n = alu_result;
                        state_n  = SHOW;
                    end else begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (alu_rvalid) begin
                        result_n = alu_result;
                        state_n  = SHOW;
                    end else if (wcnt == WAIT_LAST) begin
                        err_n    = 1'b1;
                        result_n = '0;
                        state_n  = SHOW;
                    end else begin
                        wcnt_n = wcnt + TW'(1);
                    end
                end
                SHOW: if (enter_press) begin
                    state_n = GET_A;
                end
                default: state_n = GET_A;
            endcase
        end

        valid_n = (state_n == ISSUE);
        busy_n  = (state_n == ISSUE) || (state_n == WAIT);
        case (state_n)
            GET_A:   stage_n = 2'd0;
            GET_B:   stage_n = 2'd1;
            GET_OP:  stage_n = 2'd2;
            default: stage_n = 2'd3;
        endcase
    end

    always_comb begin
        case (state)
            GET_A, GET_B: disp_val = sw;
            GET_OP:       disp_val = {1'b0, sw_op};
            SHOW:         disp_val = result;
            default:      disp_val = '0;
        endcase
    end
endmodule
